// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory request port between NUM_MASTERS requesters. At most one
// transaction is in flight: a master is granted in IDLE, its request fields are
// captured and presented to memory in REQ until accepted, and the arbiter then
// waits in RESP for the memory response (read data or write ack), which is
// forwarded as a single-cycle pulse to the owning master only.
//
// Parameters
//   NUM_MASTERS  number of requesters (>= 1)
//   ADDR_W       address width
//   DATA_W       data width, multiple of 8 (byte mask width MW = DATA_W/8)
//   ARB_MODE     0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports
//   clk                clock, all state on rising edge
//   rst                asynchronous active-low reset
//   m_valid/m_wen      per-master request valid / write enable
//   m_addr/m_wdata/    per-master request fields, master i at
//   m_wmask              slice [i*W +: W]
//   m_ready            request accepted this cycle (one-hot or zero)
//   m_rvalid           response pulse to the owning master (one-hot or zero)
//   m_rdata            response data, broadcast (mirrors s_rdata)
//   s_valid/s_addr/    request to memory, stable while s_valid is high
//   s_wdata/s_wmask/s_wen
//   s_ready            memory accepts the request
//   s_rvalid/s_rdata   memory response
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // Master side
  input  logic [NUM_MASTERS-1:0]                m_valid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]         m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]         m_wdata,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0]     m_wmask,
  input  logic [NUM_MASTERS-1:0]                m_wen,
  output logic [NUM_MASTERS-1:0]                m_ready,
  output logic [NUM_MASTERS-1:0]                m_rvalid,
  output logic [DATA_W-1:0]                     m_rdata,
  // Memory side
  output logic                                  s_valid,
  output logic [ADDR_W-1:0]                     s_addr,
  output logic [DATA_W-1:0]                     s_wdata,
  output logic [(DATA_W/8)-1:0]                 s_wmask,
  output logic                                  s_wen,
  input  logic                                  s_ready,
  input  logic                                  s_rvalid,
  input  logic [DATA_W-1:0]                     s_rdata
);

  localparam int MW    = DATA_W / 8;
  // Index width kept at least 1 bit so a single-master build stays legal.
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;   // round-robin search start
  logic [IDX_W-1:0]   id_q, id_d;           // owner of the in-flight transaction
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [MW-1:0]      wmask_q, wmask_d;
  logic               wen_q, wen_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // Round-robin walks the masters starting at rr_ptr_q and wrapping; fixed
  // priority walks from index 0. The first valid master met is the winner.
  // ---------------------------------------------------------------------------
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (ARB_MODE == 0) begin
        cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      end else begin
        cand = IDX_W'(k);
      end
      if (!grant_vld && m_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    wen_d    = wen_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_REQ;
          id_d    = grant_idx;
          addr_d  = m_addr [grant_idx*ADDR_W +: ADDR_W];
          wdata_d = m_wdata[grant_idx*DATA_W +: DATA_W];
          wmask_d = m_wmask[grant_idx*MW     +: MW];
          wen_d   = m_wen  [grant_idx];
          if (ARB_MODE == 0) begin
            rr_ptr_d = IDX_W'((int'(grant_idx) + 1) % NUM_MASTERS);
          end
        end
      end

      ST_REQ: begin
        if (s_ready) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // Responses arriving in IDLE or REQ never reach this branch and are
        // therefore dropped.
        if (s_rvalid) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the captured request fields are reset too, not only the control
      // state, because they drive the memory port directly and must read as
      // zero while reset is held.
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wen_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the same pre-edge state.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      wen_q    <= wen_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Grant is combinational in IDLE so the master sees acceptance in the same
  // cycle it is chosen. Gating with rst keeps it low while reset is asserted,
  // even though IDLE is the reset state.
  always_comb begin
    m_ready  = '0;
    m_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_ready[i]  = rst && (state_q == ST_IDLE) && grant_vld &&
                    (grant_idx == IDX_W'(i));
      m_rvalid[i] = (state_q == ST_RESP) && s_rvalid && (id_q == IDX_W'(i));
    end
  end

  assign m_rdata = s_rdata;

  // Memory request comes straight from registers: stable for the whole REQ
  // phase regardless of what the masters do meanwhile.
  assign s_valid = (state_q == ST_REQ);
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wmask = wmask_q;
  assign s_wen   = wen_q;

  // ---------------------------------------------------------------------------
  // Protocol sanity
  // ---------------------------------------------------------------------------
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(m_ready));
  a_rvalid_onehot0 : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(m_rvalid));
  a_ready_only_idle : assert property (@(posedge clk) disable iff (!rst)
    (state_q != ST_IDLE) |-> (m_ready == '0));

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Three arbiters share one stimulus stream:
//   d0 : NUM_MASTERS=2, round-robin
//   d1 : NUM_MASTERS=2, fixed priority
//   d2 : NUM_MASTERS=1 (sees master 0's inputs only)
// A transaction-level reference model (busy / sent flags, a pointer and a
// captured request per instance) predicts every output each cycle. Directed
// scenarios come first, then randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int N  = 2;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_wen;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*MW-1:0] m_wmask;
  logic            s_ready;
  logic            s_rvalid;
  logic [DW-1:0]   s_rdata;

  // Per-instance outputs
  logic [N-1:0] r0_m_ready, r0_m_rvalid, r1_m_ready, r1_m_rvalid;
  logic         r2_m_ready, r2_m_rvalid;
  logic [DW-1:0] r0_m_rdata, r1_m_rdata, r2_m_rdata;
  logic          r0_s_valid, r1_s_valid, r2_s_valid;
  logic [AW-1:0] r0_s_addr, r1_s_addr, r2_s_addr;
  logic [DW-1:0] r0_s_wdata, r1_s_wdata, r2_s_wdata;
  logic [MW-1:0] r0_s_wmask, r1_s_wmask, r2_s_wmask;
  logic          r0_s_wen, r1_s_wen, r2_s_wen;

  mem_arbiter #(.NUM_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u_d0 (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wen(m_wen),
    .m_ready(r0_m_ready), .m_rvalid(r0_m_rvalid), .m_rdata(r0_m_rdata),
    .s_valid(r0_s_valid), .s_addr(r0_s_addr), .s_wdata(r0_s_wdata), .s_wmask(r0_s_wmask),
    .s_wen(r0_s_wen), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata));

  mem_arbiter #(.NUM_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) u_d1 (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wen(m_wen),
    .m_ready(r1_m_ready), .m_rvalid(r1_m_rvalid), .m_rdata(r1_m_rdata),
    .s_valid(r1_s_valid), .s_addr(r1_s_addr), .s_wdata(r1_s_wdata), .s_wmask(r1_s_wmask),
    .s_wen(r1_s_wen), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata));

  mem_arbiter #(.NUM_MASTERS(1), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u_d2 (
    .clk(clk), .rst(rst),
    .m_valid(m_valid[0:0]), .m_addr(m_addr[AW-1:0]), .m_wdata(m_wdata[DW-1:0]),
    .m_wmask(m_wmask[MW-1:0]), .m_wen(m_wen[0:0]),
    .m_ready(r2_m_ready), .m_rvalid(r2_m_rvalid), .m_rdata(r2_m_rdata),
    .s_valid(r2_s_valid), .s_addr(r2_s_addr), .s_wdata(r2_s_wdata), .s_wmask(r2_s_wmask),
    .s_wen(r2_s_wen), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata));

  // Gather outputs into arrays for the model comparison loop
  logic [N-1:0]  o_ready [ND];
  logic [N-1:0]  o_rvalid[ND];
  logic [DW-1:0] o_rdata [ND];
  logic          o_svalid[ND];
  logic [AW-1:0] o_saddr [ND];
  logic [DW-1:0] o_swdata[ND];
  logic [MW-1:0] o_swmask[ND];
  logic          o_swen  [ND];

  always_comb begin
    o_ready[0]  = r0_m_ready;  o_ready[1]  = r1_m_ready;  o_ready[2]  = {1'b0, r2_m_ready};
    o_rvalid[0] = r0_m_rvalid; o_rvalid[1] = r1_m_rvalid; o_rvalid[2] = {1'b0, r2_m_rvalid};
    o_rdata[0]  = r0_m_rdata;  o_rdata[1]  = r1_m_rdata;  o_rdata[2]  = r2_m_rdata;
    o_svalid[0] = r0_s_valid;  o_svalid[1] = r1_s_valid;  o_svalid[2] = r2_s_valid;
    o_saddr[0]  = r0_s_addr;   o_saddr[1]  = r1_s_addr;   o_saddr[2]  = r2_s_addr;
    o_swdata[0] = r0_s_wdata;  o_swdata[1] = r1_s_wdata;  o_swdata[2] = r2_s_wdata;
    o_swmask[0] = r0_s_wmask;  o_swmask[1] = r1_s_wmask;  o_swmask[2] = r2_s_wmask;
    o_swen[0]   = r0_s_wen;    o_swen[1]   = r1_s_wen;    o_swen[2]   = r2_s_wen;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int nm[ND] = '{2, 2, 1};   // masters per instance
  int md[ND] = '{0, 1, 0};   // 0 round-robin, 1 fixed priority

  bit            busy[ND];   // a request has been accepted and not yet answered
  bit            sent[ND];   // memory has accepted it
  int            ptr [ND];
  int            own [ND];
  logic [AW-1:0] l_addr [ND];
  logic [DW-1:0] l_wdata[ND];
  logic [MW-1:0] l_wmask[ND];
  logic          l_wen  [ND];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] vis_valid(int d);
    return (nm[d] == 2) ? m_valid : {1'b0, m_valid[0]};
  endfunction

  // Index of the master that should win, or -1 if nobody requests.
  function automatic int winner(int d);
    logic [N-1:0] v = vis_valid(d);
    for (int k = 0; k < nm[d]; k++) begin
      int idx = (md[d] == 0) ? (ptr[d] + k) % nm[d] : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      busy[d] = 0; sent[d] = 0; ptr[d] = 0; own[d] = 0;
      l_addr[d] = '0; l_wdata[d] = '0; l_wmask[d] = '0; l_wen[d] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < ND; d++) begin
      logic [N-1:0] e_ready, e_rvalid;
      logic         e_svalid;
      int           w;
      e_ready = '0; e_rvalid = '0; e_svalid = 1'b0;
      if (rst) begin
        w = winner(d);
        if (!busy[d] && w >= 0) e_ready = N'(1) << w;
        if (busy[d] && sent[d] && s_rvalid) e_rvalid = N'(1) << own[d];
        e_svalid = busy[d] && !sent[d];
      end
      check($sformatf("d%0d m_ready", d),  64'(o_ready[d]),  64'(e_ready));
      check($sformatf("d%0d m_rvalid", d), 64'(o_rvalid[d]), 64'(e_rvalid));
      check($sformatf("d%0d m_rdata", d),  64'(o_rdata[d]),  64'(s_rdata));
      check($sformatf("d%0d s_valid", d),  64'(o_svalid[d]), 64'(e_svalid));
      check($sformatf("d%0d s_addr", d),   64'(o_saddr[d]),  rst ? 64'(l_addr[d])  : 64'd0);
      check($sformatf("d%0d s_wdata", d),  64'(o_swdata[d]), rst ? 64'(l_wdata[d]) : 64'd0);
      check($sformatf("d%0d s_wmask", d),  64'(o_swmask[d]), rst ? 64'(l_wmask[d]) : 64'd0);
      check($sformatf("d%0d s_wen", d),    64'(o_swen[d]),   rst ? 64'(l_wen[d])   : 64'd0);
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      int w = winner(d);
      if (!busy[d]) begin
        if (w >= 0) begin
          busy[d] = 1; sent[d] = 0; own[d] = w;
          l_addr[d]  = m_addr [w*AW +: AW];
          l_wdata[d] = m_wdata[w*DW +: DW];
          l_wmask[d] = m_wmask[w*MW +: MW];
          l_wen[d]   = m_wen[w];
          if (md[d] == 0) ptr[d] = (w + 1) % nm[d];
        end
      end else if (!sent[d]) begin
        if (s_ready) sent[d] = 1;
      end else if (s_rvalid) begin
        busy[d] = 0;
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are compared 1 ns later and the
  // model advances at the following rising edge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_valid = '0; m_wen = '0; m_addr = '0; m_wdata = '0; m_wmask = '0;
    s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  // One full transaction with the fastest memory; reports the grants seen.
  task automatic txn(output logic [N-1:0] g0, output logic [N-1:0] g1);
    s_ready = 1'b0; s_rvalid = 1'b0;
    #1;
    g0 = r0_m_ready;
    g1 = r1_m_ready;
    cycle();
    s_ready = 1'b1;
    cycle();
    s_ready = 1'b0; s_rvalid = 1'b1;
    cycle();
    s_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g0, g1;
    logic [N-1:0] rr_exp[4];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    idle_inputs();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    m_valid = 2'b11;                    // requests present while in reset
    #1;
    check("reset m_ready", 64'(r0_m_ready), 64'd0);
    cycle();
    m_valid = '0;
    cycle();
    rst = 1'b1;

    // Round-robin vs fixed priority under continuous contention
    m_valid = 2'b11;
    m_addr  = {32'h2000_0000, 32'h1000_0000};
    for (int t = 0; t < 4; t++) begin
      txn(g0, g1);
      check($sformatf("rr grant %0d", t), 64'(g0), 64'(rr_exp[t]));
      check($sformatf("fp grant %0d", t), 64'(g1), 64'(2'b01));
    end
    m_valid = 2'b10;
    txn(g0, g1);
    check("rr grant m1 alone", 64'(g0), 64'(2'b10));
    check("fp grant m1 alone", 64'(g1), 64'(2'b10));
    m_valid = '0;
    cycle();

    // Single read, fastest memory
    m_valid = 2'b01; m_wen = 2'b00;
    m_addr  = {32'h0, 32'h8000_0000};
    s_ready = 1'b1;
    #1;
    check("read grant", 64'(r0_m_ready), 64'(2'b01));
    cycle();
    m_valid = '0;
    #1;
    check("read s_valid", 64'(r0_s_valid), 64'd1);
    check("read s_addr", 64'(r0_s_addr), 64'h8000_0000);
    cycle();
    s_ready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    check("read m_rvalid", 64'(r0_m_rvalid), 64'(2'b01));
    check("read m_rdata", 64'(r0_m_rdata), 64'hDEAD_BEEF);
    cycle();
    s_rvalid = 1'b0;
    #1;
    check("read rvalid pulse", 64'(r0_m_rvalid), 64'd0);
    cycle();

    // Backpressure: request fields held, late response in REQ ignored
    m_valid = 2'b01; m_wen = 2'b01;
    m_addr  = {32'h0, 32'h1000_0040};
    m_wdata = {32'h0, 32'hCAFE_F00D};
    m_wmask = {4'h0, 4'hF};
    cycle();
    m_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      m_addr   = {$urandom, $urandom};
      m_wdata  = {$urandom, $urandom};
      m_wmask  = 8'($urandom);
      s_rvalid = (i == 2);
      #1;
      check("bp s_valid", 64'(r0_s_valid), 64'd1);
      check("bp s_addr",  64'(r0_s_addr),  64'h1000_0040);
      check("bp s_wdata", 64'(r0_s_wdata), 64'hCAFE_F00D);
      check("bp s_wmask", 64'(r0_s_wmask), 64'hF);
      check("bp m_ready", 64'(r0_m_ready), 64'd0);
      check("bp m_rvalid", 64'(r0_m_rvalid), 64'd0);
      cycle();
    end
    s_rvalid = 1'b0; s_ready = 1'b1;
    cycle();
    s_ready = 1'b0; s_rvalid = 1'b1; m_valid = '0;
    cycle();
    s_rvalid = 1'b0;
    cycle();

    // Write acknowledged via s_rvalid, only to the writer
    m_valid = 2'b10; m_wen = 2'b10;
    m_wdata = {32'h0000_1234, 32'h0};
    m_wmask = {4'h3, 4'h0};
    #1;
    check("wr grant rr", 64'(r0_m_ready), 64'(2'b10));
    check("wr grant fp", 64'(r1_m_ready), 64'(2'b10));
    cycle();
    m_valid = '0; s_ready = 1'b1;
    #1;
    check("wr s_wen",   64'(r0_s_wen),   64'd1);
    check("wr s_wmask", 64'(r0_s_wmask), 64'h3);
    check("wr s_wdata", 64'(r0_s_wdata), 64'h1234);
    cycle();
    s_ready = 1'b0; s_rvalid = 1'b1;
    #1;
    check("wr ack rr", 64'(r0_m_rvalid), 64'(2'b10));
    check("wr ack fp", 64'(r1_m_rvalid), 64'(2'b10));
    cycle();
    s_rvalid = 1'b0; m_wen = '0;
    cycle();

    // Reset while waiting for the response
    m_valid = 2'b01;
    cycle();
    m_valid = '0; s_ready = 1'b1;
    cycle();
    s_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("rst resp s_valid", 64'(r0_s_valid), 64'd0);
    check("rst resp m_rvalid", 64'(r0_m_rvalid), 64'd0);
    cycle();
    rst = 1'b1; s_rvalid = 1'b1; m_valid = 2'b11;
    #1;
    check("rst late rvalid", 64'(r0_m_rvalid), 64'd0);
    check("rst regrant rr", 64'(r0_m_ready), 64'(2'b01));
    check("rst regrant fp", 64'(r1_m_ready), 64'(2'b01));
    cycle();
    s_rvalid = 1'b0; s_ready = 1'b1; m_valid = '0;
    cycle();
    s_ready = 1'b0; s_rvalid = 1'b1;
    cycle();
    s_rvalid = 1'b0;
    cycle();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      m_valid  = 2'($urandom);
      m_wen    = 2'($urandom);
      m_addr   = {$urandom, $urandom};
      m_wdata  = {$urandom, $urandom};
      m_wmask  = 8'($urandom);
      s_ready  = ($urandom_range(0, 2) != 0);
      s_rvalid = ($urandom_range(0, 2) == 0);
      s_rdata  = $urandom;
      rst      = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst = 1'b1;
    idle_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
